// File: rtl/trap_csr_pkg.sv
// Shared definitions for the machine-mode trap/interrupt unit.
// Holds the pipeline stage indices, CSR address map, mstatus/mie bit
// positions, interrupt cause codes and control_op encodings.
package trap_csr_pkg;

    // Stage indexing of the one-hot stage vector driven by fsm.
    localparam int NUM_STAGES    = 5;
    localparam int STAGE_FETCH   = 0;
    localparam int STAGE_DECODE  = 1;
    localparam int STAGE_EXECUTE = 2;
    localparam int STAGE_CONTROL = 3;
    localparam int STAGE_WRITE   = 4;

    // CSR addresses.
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    // mstatus / mie / mip bit indices.
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MSIE     = 3;
    localparam int MIE_MEIE     = 11;

    // Interrupt cause values written to mcause.
    localparam logic [31:0] CAUSE_EXT_INT = 32'h8000_000B;
    localparam logic [31:0] CAUSE_SW_INT  = 32'h8000_0003;

    typedef enum logic [1:0] {
        CTRL_TRAP    = 2'b00,
        CTRL_EXT_INT = 2'b01,
        CTRL_SW_INT  = 2'b10,
        CTRL_NORMAL  = 2'b11
    } control_op_t;

endpackage

// File: rtl/trap_csr_reg32.sv
// csr_reg32: 32-bit register with enable, per-bit write mask and
// asynchronous active-low clear.
//   clk, reset_n : clock and async clear
//   en           : load enable
//   mask         : bits set to 1 take d on load; others hold
//   d / q        : data in / registered value
module csr_reg32 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [31:0] mask,
    input  logic [31:0] d,
    output logic [31:0] q
);

    logic [31:0] q_next;

    always_comb begin
        q_next = q;
        if (en) begin
            q_next = (q & ~mask) | (d & mask);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/trap_csr.sv
// trap_csr: machine-mode trap and interrupt state.
// Commits traps, interrupts and MRET on the first cycle of each control-stage
// visit, owns the mstatus/mie/mtvec/mepc/mcause/mip CSR port, and produces
// the masked interrupt requests consumed by fsm.
//   clk, reset_n         : clock, async active-low reset
//   stage_active         : one-hot stage from fsm
//   control_op, fault_num: commit type and fault code
//   pc, next_pc, mret    : current PC, successor PC, decoded MRET
//   csr_we/addr/wdata    : CSR write port; csr_rdata is a combinational read
//   ext_irq, sw_irq      : raw interrupt lines
//   ext_int, sw_int      : masked interrupt requests
//   redirect, redirect_pc: one-cycle PC redirect and its target
module trap_csr
    import trap_csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_STAGES-1:0] stage_active,
    input  logic [1:0]            control_op,
    input  logic [2:0]            fault_num,
    input  logic [XLEN-1:0]       pc,
    input  logic [XLEN-1:0]       next_pc,
    input  logic                  mret,
    input  logic                  csr_we,
    input  logic [11:0]           csr_addr,
    input  logic [XLEN-1:0]       csr_wdata,
    output logic [XLEN-1:0]       csr_rdata,
    input  logic                  ext_irq,
    input  logic                  sw_irq,
    output logic                  ext_int,
    output logic                  sw_int,
    output logic                  redirect,
    output logic [XLEN-1:0]       redirect_pc
);

    logic ctrl_prev;
    logic ctrl_entry;
    logic commit_trap;
    logic commit_int;
    logic commit_mret;
    logic commit_take;

    logic mie_bit, mpie_bit, msie_bit, meie_bit;
    logic mie_next, mpie_next, msie_next, meie_next;

    logic [31:0] mtvec, mepc, mcause;
    logic        mtvec_en, mepc_en, mcause_en;
    logic [31:0] mepc_d, mcause_d;

    logic unused_stages;
    assign unused_stages = ^{stage_active[STAGE_FETCH], stage_active[STAGE_DECODE],
                             stage_active[STAGE_EXECUTE], stage_active[STAGE_WRITE]};

    // Edge detect on the control stage bit gives one commit per visit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_prev <= 1'b0;
        end else begin
            ctrl_prev <= stage_active[STAGE_CONTROL];
        end
    end

    assign ctrl_entry  = stage_active[STAGE_CONTROL] & ~ctrl_prev;
    assign commit_trap = ctrl_entry && (control_op == CTRL_TRAP);
    assign commit_int  = ctrl_entry && ((control_op == CTRL_EXT_INT) ||
                                        (control_op == CTRL_SW_INT));
    assign commit_mret = ctrl_entry && (control_op == CTRL_NORMAL) && mret;
    assign commit_take = commit_trap | commit_int;

    // mstatus / mie bits: commit updates take precedence over CSR writes.
    always_comb begin
        mie_next  = mie_bit;
        mpie_next = mpie_bit;
        msie_next = msie_bit;
        meie_next = meie_bit;
        if (commit_take) begin
            mpie_next = mie_bit;
            mie_next  = 1'b0;
        end else if (commit_mret) begin
            mie_next  = mpie_bit;
            mpie_next = 1'b1;
        end else if (csr_we && csr_addr == CSR_MSTATUS) begin
            mie_next  = csr_wdata[MSTATUS_MIE];
            mpie_next = csr_wdata[MSTATUS_MPIE];
        end
        if (csr_we && csr_addr == CSR_MIE) begin
            msie_next = csr_wdata[MIE_MSIE];
            meie_next = csr_wdata[MIE_MEIE];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mie_bit  <= 1'b0;
            mpie_bit <= 1'b0;
            msie_bit <= 1'b0;
            meie_bit <= 1'b0;
        end else begin
            mie_bit  <= mie_next;
            mpie_bit <= mpie_next;
            msie_bit <= msie_next;
            meie_bit <= meie_next;
        end
    end

    // mtvec low bits are masked off, so they stay at their reset value of 0.
    assign mtvec_en = csr_we && (csr_addr == CSR_MTVEC);

    csr_reg32 u_mtvec (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (mtvec_en),
        .mask    (32'hFFFF_FFFC),
        .d       (csr_wdata),
        .q       (mtvec)
    );

    assign mepc_en = commit_take | (csr_we && (csr_addr == CSR_MEPC));
    assign mepc_d  = commit_trap ? pc :
                     commit_int  ? next_pc :
                                   (csr_wdata & 32'hFFFF_FFFC);

    csr_reg32 u_mepc (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (mepc_en),
        .mask    (32'hFFFF_FFFF),
        .d       (mepc_d),
        .q       (mepc)
    );

    assign mcause_en = commit_take | (csr_we && (csr_addr == CSR_MCAUSE));
    always_comb begin
        mcause_d = csr_wdata;
        if (commit_trap) begin
            mcause_d = {29'b0, fault_num};
        end else if (commit_int) begin
            mcause_d = (control_op == CTRL_EXT_INT) ? CAUSE_EXT_INT : CAUSE_SW_INT;
        end
    end

    csr_reg32 u_mcause (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (mcause_en),
        .mask    (32'hFFFF_FFFF),
        .d       (mcause_d),
        .q       (mcause)
    );

    // redirect_pc holds its last target between redirects.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            redirect <= commit_take | commit_mret;
            if (commit_take) begin
                redirect_pc <= mtvec;
            end else if (commit_mret) begin
                redirect_pc <= mepc;
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_rdata[MSTATUS_MIE]  = mie_bit;
                csr_rdata[MSTATUS_MPIE] = mpie_bit;
            end
            CSR_MIE: begin
                csr_rdata[MIE_MSIE] = msie_bit;
                csr_rdata[MIE_MEIE] = meie_bit;
            end
            CSR_MTVEC:  csr_rdata = mtvec;
            CSR_MEPC:   csr_rdata = mepc;
            CSR_MCAUSE: csr_rdata = mcause;
            CSR_MIP: begin
                csr_rdata[MIE_MEIE] = ext_irq;
                csr_rdata[MIE_MSIE] = sw_irq;
            end
            default:    csr_rdata = '0;
        endcase
    end

    assign ext_int = ext_irq & mie_bit & meie_bit;
    assign sw_int  = sw_irq  & mie_bit & msie_bit;

endmodule

// File: tb/tb_trap_csr.sv
module tb_trap_csr;
    import trap_csr_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic [NUM_STAGES-1:0] stage_active = '0;
    logic [1:0]            control_op = 2'b11;
    logic [2:0]            fault_num = '0;
    logic [31:0]           pc = '0;
    logic [31:0]           next_pc = '0;
    logic                  mret = 1'b0;
    logic                  csr_we = 1'b0;
    logic [11:0]           csr_addr = '0;
    logic [31:0]           csr_wdata = '0;
    logic [31:0]           csr_rdata;
    logic                  ext_irq = 1'b0;
    logic                  sw_irq = 1'b0;
    logic                  ext_int;
    logic                  sw_int;
    logic                  redirect;
    logic [31:0]           redirect_pc;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state (architectural view only).
    logic        m_mie, m_mpie, m_msie, m_meie;
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_rpc;
    logic        m_red, m_prev_ctrl;

    trap_csr #(.XLEN(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .stage_active(stage_active),
        .control_op  (control_op),
        .fault_num   (fault_num),
        .pc          (pc),
        .next_pc     (next_pc),
        .mret        (mret),
        .csr_we      (csr_we),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .ext_irq     (ext_irq),
        .sw_irq      (sw_irq),
        .ext_int     (ext_int),
        .sw_int      (sw_int),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_msie = 0; m_meie = 0;
        m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_rpc = 0;
        m_red = 0; m_prev_ctrl = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            12'h300: begin r[3] = m_mie; r[7] = m_mpie; end
            12'h304: begin r[3] = m_msie; r[11] = m_meie; end
            12'h305: r = m_mtvec;
            12'h341: r = m_mepc;
            12'h342: r = m_mcause;
            12'h344: begin r[11] = ext_irq; r[3] = sw_irq; end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Apply the architectural effect of the coming clock edge to the model.
    task automatic model_edge();
        logic entry, take_t, take_i, ret;
        logic o_mie, o_mpie;
        logic [31:0] o_mtvec, o_mepc;
        entry  = stage_active[STAGE_CONTROL] && !m_prev_ctrl;
        take_t = entry && control_op == 2'b00;
        take_i = entry && (control_op == 2'b01 || control_op == 2'b10);
        ret    = entry && control_op == 2'b11 && mret;
        o_mie = m_mie; o_mpie = m_mpie; o_mtvec = m_mtvec; o_mepc = m_mepc;
        m_red = take_t || take_i || ret;
        if (take_t || take_i) begin
            m_mepc   = take_t ? pc : next_pc;
            m_mcause = take_t ? {29'b0, fault_num} :
                       (control_op == 2'b01 ? 32'h8000_000B : 32'h8000_0003);
            m_mpie = o_mie; m_mie = 0; m_rpc = o_mtvec;
        end else if (ret) begin
            m_mie = o_mpie; m_mpie = 1; m_rpc = o_mepc;
        end
        if (csr_we) begin
            case (csr_addr)
                12'h300: if (!m_red) begin m_mie = csr_wdata[3]; m_mpie = csr_wdata[7]; end
                12'h304: begin m_msie = csr_wdata[3]; m_meie = csr_wdata[11]; end
                12'h305: m_mtvec = csr_wdata & 32'hFFFF_FFFC;
                12'h341: if (!(take_t || take_i)) m_mepc = csr_wdata & 32'hFFFF_FFFC;
                12'h342: if (!(take_t || take_i)) m_mcause = csr_wdata;
                default: ;
            endcase
        end
        m_prev_ctrl = stage_active[STAGE_CONTROL];
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        csr_we = 0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        csr_we = 0;
        csr_addr = a;
        #1;
        d = csr_rdata;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_we = 1; csr_addr = a; csr_wdata = d;
        step();
    endtask

    task automatic set_ctrl(input logic on);
        stage_active = '0;
        stage_active[on ? STAGE_CONTROL : STAGE_EXECUTE] = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        #1;
        rd(12'h300, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_mstatus got %h exp %h", d, 32'h0); end
        rd(12'h305, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_mtvec got %h exp %h", d, 32'h0); end
        n_cmp++; if (redirect !== 1'b0 || redirect_pc !== 32'h0) begin
            n_err++; $display("FAIL reset_redirect got %b/%h exp 0/0", redirect, redirect_pc); end
        @(negedge clk);
        reset_n = 1;
        model_reset();
        set_ctrl(0);
        @(posedge clk); #1;
    endtask

    task automatic test_readback();
        logic [31:0] d;
        csr_write(12'h305, 32'h0000_0103);
        rd(12'h305, d);
        n_cmp++; if (d !== 32'h0000_0100) begin n_err++; $display("FAIL mtvec_align got %h exp %h", d, 32'h100); end
        ext_irq = 1; #1;
        n_cmp++; if (ext_int !== 1'b0) begin n_err++; $display("FAIL ext_int_masked got %b exp 0", ext_int); end
        rd(12'h344, d);
        n_cmp++; if (d !== 32'h0000_0800) begin n_err++; $display("FAIL mip_read got %h exp %h", d, 32'h800); end
        rd(12'h123, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL unmapped_read got %h exp 0", d); end
        ext_irq = 0;
    endtask

    task automatic test_trap();
        logic [31:0] d;
        csr_write(12'h300, 32'h0000_0008);
        set_ctrl(1); control_op = 2'b00; fault_num = 3'b110; pc = 32'h40; next_pc = 32'h44;
        step();
        rd(12'h342, d);
        n_cmp++; if (d !== 32'h6) begin n_err++; $display("FAIL trap_mcause got %h exp %h", d, 32'h6); end
        rd(12'h341, d);
        n_cmp++; if (d !== 32'h40) begin n_err++; $display("FAIL trap_mepc got %h exp %h", d, 32'h40); end
        rd(12'h300, d);
        n_cmp++; if (d !== 32'h80) begin n_err++; $display("FAIL trap_mstatus got %h exp %h", d, 32'h80); end
        n_cmp++; if (redirect !== 1'b1 || redirect_pc !== 32'h100) begin
            n_err++; $display("FAIL trap_redirect got %b/%h exp 1/%h", redirect, redirect_pc, 32'h100); end
        step();
        n_cmp++; if (redirect !== 1'b0) begin n_err++; $display("FAIL trap_redirect_len got %b exp 0", redirect); end
        set_ctrl(0); control_op = 2'b11;
        step();
    endtask

    task automatic test_mret();
        logic [31:0] d;
        set_ctrl(1); control_op = 2'b11; mret = 1;
        step();
        rd(12'h300, d);
        n_cmp++; if (d !== 32'h88) begin n_err++; $display("FAIL mret_mstatus got %h exp %h", d, 32'h88); end
        n_cmp++; if (redirect !== 1'b1 || redirect_pc !== 32'h40) begin
            n_err++; $display("FAIL mret_redirect got %b/%h exp 1/%h", redirect, redirect_pc, 32'h40); end
        step();
        n_cmp++; if (redirect !== 1'b0) begin n_err++; $display("FAIL mret_second got %b exp 0", redirect); end
        set_ctrl(0); mret = 0;
        step();
    endtask

    task automatic test_ext_int();
        logic [31:0] d;
        csr_write(12'h300, 32'h8);
        csr_write(12'h304, 32'h800);
        ext_irq = 1; #1;
        n_cmp++; if (ext_int !== 1'b1) begin n_err++; $display("FAIL ext_int_on got %b exp 1", ext_int); end
        set_ctrl(1); control_op = 2'b01; next_pc = 32'h84; pc = 32'h80;
        step();
        rd(12'h342, d);
        n_cmp++; if (d !== 32'h8000_000B) begin n_err++; $display("FAIL ext_mcause got %h exp %h", d, 32'h8000_000B); end
        rd(12'h341, d);
        n_cmp++; if (d !== 32'h84) begin n_err++; $display("FAIL ext_mepc got %h exp %h", d, 32'h84); end
        n_cmp++; if (ext_int !== 1'b0) begin n_err++; $display("FAIL ext_int_drop got %b exp 0", ext_int); end
        step();
        set_ctrl(0); control_op = 2'b11; ext_irq = 0;
        step();
    endtask

    task automatic test_collision();
        logic [31:0] d;
        set_ctrl(1); control_op = 2'b00; pc = 32'h40; fault_num = 3'b010;
        csr_we = 1; csr_addr = 12'h341; csr_wdata = 32'h200;
        step();
        rd(12'h341, d);
        n_cmp++; if (d !== 32'h40) begin n_err++; $display("FAIL collide_mepc got %h exp %h", d, 32'h40); end
        step();
        set_ctrl(0);
        step();
        set_ctrl(1);
        csr_we = 1; csr_addr = 12'h305; csr_wdata = 32'h204;
        step();
        rd(12'h305, d);
        n_cmp++; if (d !== 32'h204) begin n_err++; $display("FAIL collide_mtvec got %h exp %h", d, 32'h204); end
        n_cmp++; if (redirect_pc !== 32'h100) begin n_err++; $display("FAIL collide_rpc got %h exp %h", redirect_pc, 32'h100); end
        step();
        set_ctrl(0); control_op = 2'b11;
        step();
    endtask

    task automatic test_reset_mid_commit();
        logic [31:0] d;
        set_ctrl(1); control_op = 2'b00; pc = 32'h48; fault_num = 3'b101;
        step();
        n_cmp++; if (redirect !== 1'b1) begin n_err++; $display("FAIL rmc_pre got %b exp 1", redirect); end
        #1 reset_n = 0;
        #1;
        n_cmp++; if (redirect !== 1'b0 || redirect_pc !== 32'h0) begin
            n_err++; $display("FAIL rmc_redirect got %b/%h exp 0/0", redirect, redirect_pc); end
        rd(12'h341, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rmc_mepc got %h exp 0", d); end
        rd(12'h342, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rmc_mcause got %h exp 0", d); end
        set_ctrl(0); control_op = 2'b11;
        model_reset();
        #1 reset_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [11:0] addrs [7];
        logic [31:0] d;
        int phase;
        addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h7C0};
        phase = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < 7; k++) begin
                rd(addrs[k], d);
                n_cmp++; if (d !== m_read(addrs[k])) begin
                    n_err++; $display("FAIL rand_csr cyc %0d addr %h got %h exp %h", cyc, addrs[k], d, m_read(addrs[k])); end
            end
            n_cmp++; if (redirect !== m_red || redirect_pc !== m_rpc) begin
                n_err++; $display("FAIL rand_redirect cyc %0d got %b/%h exp %b/%h", cyc, redirect, redirect_pc, m_red, m_rpc); end
            n_cmp++; if (ext_int !== (ext_irq & m_mie & m_meie) || sw_int !== (sw_irq & m_mie & m_msie)) begin
                n_err++; $display("FAIL rand_int cyc %0d got %b%b exp %b%b", cyc, ext_int, sw_int,
                                  ext_irq & m_mie & m_meie, sw_irq & m_mie & m_msie); end
            // Visits are two cycles long with at least one idle cycle between.
            if (phase == 0 && $urandom_range(0, 2) == 0) phase = 1;
            else if (phase == 1) phase = 2;
            else phase = 0;
            set_ctrl(phase != 0);
            if (phase == 1) begin
                control_op = 2'($urandom_range(0, 3));
                fault_num  = 3'($urandom);
                pc         = $urandom;
                next_pc    = $urandom;
            end
            mret    = 1'($urandom);
            ext_irq = 1'($urandom);
            sw_irq  = 1'($urandom);
            csr_we    = ($urandom_range(0, 2) == 0);
            csr_addr  = addrs[$urandom_range(0, 6)];
            csr_wdata = $urandom;
            step();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_readback();
        test_trap();
        test_mret();
        test_ext_int();
        test_collision();
        test_reset_mid_commit();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
